// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory port between instruction fetch and data access.
// Ties alternate on the last grant; a stalled transfer is aborted after TIMEOUT cycles.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_done,
   output logic [31:0] fetch_rdata,
   output logic        fetch_err,
   input  logic        data_req,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_done,
   output logic [31:0] data_rdata,
   output logic        data_err,
   output logic        mem_ready,
   input  logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   // state    | meaning
   // ST_IDLE  | port free, arbitrating between requests
   // ST_FETCH | fetch transfer outstanding on the memory port
   // ST_DATA  | load/store transfer outstanding on the memory port
   // ST_DONE  | one-cycle done pulse to the granted requester
   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DATA, ST_DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        last_data_q, last_data_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_ready_q, mem_ready_d;
   logic        mem_instr_q, mem_instr_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        fetch_done_q, fetch_done_d;
   logic [31:0] fetch_rdata_q, fetch_rdata_d;
   logic        fetch_err_q, fetch_err_d;
   logic        data_done_q, data_done_d;
   logic [31:0] data_rdata_q, data_rdata_d;
   logic        data_err_q, data_err_d;
   logic        grant_data;
   logic        resp_hit;
   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = ^{fetch_addr[1:0], data_addr[1:0]};

   always_comb begin
      state_d       = state_q;
      last_data_d   = last_data_q;
      cnt_d         = cnt_q;
      mem_ready_d   = mem_ready_q;
      mem_instr_d   = mem_instr_q;
      mem_addr_d    = mem_addr_q;
      mem_wstrb_d   = mem_wstrb_q;
      mem_wdata_d   = mem_wdata_q;
      fetch_done_d  = 1'b0;
      fetch_rdata_d = fetch_rdata_q;
      fetch_err_d   = fetch_err_q;
      data_done_d   = 1'b0;
      data_rdata_d  = data_rdata_q;
      data_err_d    = data_err_q;
      grant_data    = 1'b0;
      resp_hit      = mem_valid && mem_ready_q;
      case (state_q)
         ST_IDLE: begin
            if (fetch_req || data_req) begin
               grant_data  = data_req && (!fetch_req || !last_data_q);
               last_data_d = grant_data;
               cnt_d       = '0;
               mem_ready_d = 1'b1;
               mem_instr_d = !grant_data;
               if (grant_data) begin
                  mem_addr_d  = {data_addr[31:2], 2'b00};
                  mem_wstrb_d = data_wstrb;
                  mem_wdata_d = data_wdata;
                  state_d     = ST_DATA;
               end else begin
                  mem_addr_d  = {fetch_addr[31:2], 2'b00};
                  mem_wstrb_d = '0;
                  mem_wdata_d = '0;
                  state_d     = ST_FETCH;
               end
            end
         end
         ST_FETCH, ST_DATA: begin
            // a response in the last allowed cycle still counts as success
            if (resp_hit || cnt_q == CNT_LAST) begin
               mem_ready_d = 1'b0;
               state_d     = ST_DONE;
               if (state_q == ST_FETCH) begin
                  fetch_done_d  = 1'b1;
                  fetch_rdata_d = resp_hit ? mem_rdata : '0;
                  fetch_err_d   = !resp_hit;
               end else begin
                  data_done_d   = 1'b1;
                  data_rdata_d  = resp_hit ? mem_rdata : '0;
                  data_err_d    = !resp_hit;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         last_data_q   <= 1'b0;
         cnt_q         <= '0;
         mem_ready_q   <= 1'b0;
         mem_instr_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wstrb_q   <= '0;
         mem_wdata_q   <= '0;
         fetch_done_q  <= 1'b0;
         fetch_rdata_q <= '0;
         fetch_err_q   <= 1'b0;
         data_done_q   <= 1'b0;
         data_rdata_q  <= '0;
         data_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_data_q   <= last_data_d;
         cnt_q         <= cnt_d;
         mem_ready_q   <= mem_ready_d;
         mem_instr_q   <= mem_instr_d;
         mem_addr_q    <= mem_addr_d;
         mem_wstrb_q   <= mem_wstrb_d;
         mem_wdata_q   <= mem_wdata_d;
         fetch_done_q  <= fetch_done_d;
         fetch_rdata_q <= fetch_rdata_d;
         fetch_err_q   <= fetch_err_d;
         data_done_q   <= data_done_d;
         data_rdata_q  <= data_rdata_d;
         data_err_q    <= data_err_d;
      end
   end

   assign mem_ready   = mem_ready_q;
   assign mem_instr   = mem_instr_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wstrb   = mem_wstrb_q;
   assign mem_wdata   = mem_wdata_q;
   assign fetch_done  = fetch_done_q;
   assign fetch_rdata = fetch_rdata_q;
   assign fetch_err   = fetch_err_q;
   assign data_done   = data_done_q;
   assign data_rdata  = data_rdata_q;
   assign data_err    = data_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4); expected completions are queued
// when a request is issued and popped when a done pulse appears.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_done;
   logic [31:0] fetch_rdata;
   logic        fetch_err;
   logic        data_req;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_done;
   logic [31:0] data_rdata;
   logic        data_err;
   logic        mem_ready;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        is_fetch;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_done  (fetch_done),
      .fetch_rdata (fetch_rdata),
      .fetch_err   (fetch_err),
      .data_req    (data_req),
      .data_addr   (data_addr),
      .data_wstrb  (data_wstrb),
      .data_wdata  (data_wdata),
      .data_done   (data_done),
      .data_rdata  (data_rdata),
      .data_err    (data_err),
      .mem_ready   (mem_ready),
      .mem_valid   (mem_valid),
      .mem_instr   (mem_instr),
      .mem_addr    (mem_addr),
      .mem_wstrb   (mem_wstrb),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic f, input logic [31:0] r, input logic e);
      exp_t x;
      x.is_fetch = f;
      x.rdata    = r;
      x.err      = e;
      return x;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
      check({tag, "_mem_instr"}, 32'(mem_instr), 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'd0);
      check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_dones"}, 32'({fetch_done, data_done}), 32'd0);
      check({tag, "_errs"}, 32'({fetch_err, data_err}), 32'd0);
      check({tag, "_fetch_rdata"}, fetch_rdata, 32'd0);
      check({tag, "_data_rdata"}, data_rdata, 32'd0);
   endtask

   // Wait for the grant, check the presented request, hold for delay cycles,
   // optionally respond, then check the completion edge.
   task automatic serve(input int exp_wait, input int delay, input logic give, input logic drop,
                        input logic [31:0] rd, input logic exp_instr, input logic [31:0] exp_addr,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
      int waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!mem_ready && waited < 20);
      if (!mem_ready) begin
         check("grant_timeout", 32'(mem_ready), 32'd1);
         return;
      end
      if (exp_wait >= 0) check("grant_latency", 32'(waited), 32'(exp_wait));
      check("mem_instr", 32'(mem_instr), 32'(exp_instr));
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
      check("mem_wdata", mem_wdata, exp_wdata);
      if (drop) begin
         fetch_req = 1'b0;
         data_req  = 1'b0;
      end
      repeat (delay) begin
         @(negedge clk);
         check("ready_held", 32'(mem_ready), 32'd1);
         check("addr_held", mem_addr, exp_addr);
      end
      if (give) begin
         mem_valid = 1'b1;
         mem_rdata = rd;
      end
      @(negedge clk);
      mem_valid = 1'b0;
      mem_rdata = $urandom;
      check("ready_drop", 32'(mem_ready), 32'd0);
      check("done_seen", 32'(fetch_done | data_done), 32'd1);
   endtask

   always @(negedge clk) begin
      if (fetch_done || data_done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'({fetch_done, data_done}), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("done_port", 32'({fetch_done, data_done}), mon_e.is_fetch ? 32'd2 : 32'd1);
            if (mon_e.is_fetch) begin
               check("fetch_rdata", fetch_rdata, mon_e.rdata);
               check("fetch_err", 32'(fetch_err), 32'(mon_e.err));
            end else begin
               check("data_rdata", data_rdata, mon_e.rdata);
               check("data_err", 32'(data_err), 32'(mon_e.err));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      data_req   = 1'b0;
      data_addr  = '0;
      data_wstrb = '0;
      data_wdata = '0;
      mem_valid  = 1'b0;
      mem_rdata  = '0;
      @(negedge clk);
      @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      // spurious response while idle
      mem_valid = 1'b1;
      mem_rdata = 32'h1234_5678;
      repeat (2) begin
         @(negedge clk);
         check("idle_ready", 32'(mem_ready), 32'd0);
      end
      mem_valid = 1'b0;
      check("idle_fetch_rdata", fetch_rdata, 32'd0);

      // tie from reset: data first, then strict alternation
      fetch_req  = 1'b1;
      fetch_addr = 32'h0000_3000;
      data_req   = 1'b1;
      data_addr  = 32'h0000_2003;
      data_wstrb = 4'b1000;
      data_wdata = 32'hAA00_0000;
      sb.push_back(mk(1'b0, 32'h1111_1111, 1'b0));
      serve(1, 0, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 32'h2000, 4'b1000, 32'hAA00_0000);
      sb.push_back(mk(1'b1, 32'h2222_2222, 1'b0));
      serve(2, 1, 1'b1, 1'b0, 32'h2222_2222, 1'b1, 32'h3000, 4'b0000, 32'h0);
      sb.push_back(mk(1'b0, 32'h3333_3333, 1'b0));
      serve(2, 0, 1'b1, 1'b0, 32'h3333_3333, 1'b0, 32'h2000, 4'b1000, 32'hAA00_0000);
      sb.push_back(mk(1'b1, 32'h4444_4444, 1'b0));
      serve(2, 0, 1'b1, 1'b0, 32'h4444_4444, 1'b1, 32'h3000, 4'b0000, 32'h0);
      fetch_req = 1'b0;
      data_req  = 1'b0;
      repeat (2) @(negedge clk);
      check("data_rdata_hold", data_rdata, 32'h3333_3333);
      check("fetch_rdata_hold", fetch_rdata, 32'h4444_4444);

      // plain fetch; stale data strobes must not leak onto the port
      data_wstrb = 4'b1111;
      fetch_req  = 1'b1;
      fetch_addr = 32'h0000_0104;
      sb.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b0));
      serve(1, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h104, 4'b0000, 32'h0);
      fetch_req = 1'b0;
      repeat (2) @(negedge clk);

      // fetch timeout
      fetch_req  = 1'b1;
      fetch_addr = 32'h0000_0200;
      sb.push_back(mk(1'b1, 32'h0, 1'b1));
      serve(1, 3, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 4'b0000, 32'h0);
      fetch_req = 1'b0;
      repeat (2) @(negedge clk);
      check("data_rdata_untouched", data_rdata, 32'h3333_3333);

      // response in the timeout cycle wins
      data_req   = 1'b1;
      data_addr  = 32'h0000_0044;
      data_wstrb = 4'b0000;
      data_wdata = 32'h0000_0055;
      sb.push_back(mk(1'b0, 32'hCAFE_F00D, 1'b0));
      serve(1, 3, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h44, 4'b0000, 32'h55);
      data_req = 1'b0;
      repeat (2) @(negedge clk);

      // requester drops its request mid-transfer
      data_req   = 1'b1;
      data_addr  = 32'h0000_1006;
      data_wstrb = 4'b0101;
      data_wdata = 32'h00AB_00CD;
      sb.push_back(mk(1'b0, 32'h0BAD_F00D, 1'b0));
      serve(1, 1, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h1004, 4'b0101, 32'h00AB_00CD);
      repeat (3) @(negedge clk);
      check("no_regrant", 32'(mem_ready), 32'd0);

      // reset in the middle of a data transfer
      data_req   = 1'b1;
      data_addr  = 32'h0000_0080;
      data_wstrb = 4'b0000;
      @(negedge clk);
      check("mid_ready", 32'(mem_ready), 32'd1);
      reset = 1'b1;
      #1;
      check_zero("mid_reset");
      data_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("post_reset_idle", 32'(mem_ready), 32'd0);
      end

      // last grant was data before reset; reset restores data priority on a tie
      fetch_req  = 1'b1;
      fetch_addr = 32'h0000_0500;
      data_req   = 1'b1;
      data_addr  = 32'h0000_0600;
      data_wdata = 32'h0;
      sb.push_back(mk(1'b0, 32'h6666_6666, 1'b0));
      serve(1, 0, 1'b1, 1'b0, 32'h6666_6666, 1'b0, 32'h600, 4'b0000, 32'h0);
      sb.push_back(mk(1'b1, 32'h7777_7777, 1'b0));
      serve(2, 0, 1'b1, 1'b0, 32'h7777_7777, 1'b1, 32'h500, 4'b0000, 32'h0);
      fetch_req = 1'b0;
      data_req  = 1'b0;
      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: cycles to wait for mem_valid before aborting a transfer; legal range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 fetch_req  in  1  instruction-fetch request; held high with stable fetch_addr until fetch_done.
REQ-005 fetch_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-006 fetch_done  out  1  one-cycle pulse; fetch complete, fetch_rdata/fetch_err valid.
REQ-007 fetch_rdata  out  32  fetched word.
REQ-008 fetch_err  out  1  timeout flag, qualified by fetch_done.
REQ-009 data_req  in  1  load/store request; held high with stable payload until data_done.
REQ-010 data_addr  in  32  data byte address; bits [1:0] ignored.
REQ-011 data_wstrb  in  4  byte write strobes; 4'b0000 = load.
REQ-012 data_wdata  in  32  store data, lane-aligned by requester.
REQ-013 data_done  out  1  one-cycle pulse; data transfer complete.
REQ-014 data_rdata  out  32  loaded word, raw (no alignment or extension).
REQ-015 data_err  out  1  timeout flag, qualified by data_done.
REQ-016 mem_ready  out  1  memory request strobe to shared port.
REQ-017 mem_valid  in  1  memory response strobe.
REQ-018 mem_instr  out  1  1 = current transfer is a fetch.
REQ-019 mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-020 mem_wstrb  out  4  write strobes; 0 for fetches.
REQ-021 mem_wdata  out  32  write data; 0 for fetches.
REQ-022 mem_rdata  in  32  read data, sampled only when mem_valid and mem_ready.

Function
REQ-023 States: IDLE, FETCH, DATA, DONE; exactly one active.
REQ-024 IDLE, neither request high: stay IDLE, mem_ready=0.
REQ-025 IDLE, one request high: grant it, latch its payload into mem_* registers, assert mem_ready next cycle, go FETCH or DATA.
REQ-026 IDLE, both high: grant the port not granted last (last_grant register); after reset last_grant=fetch, so data wins the first tie.
REQ-027 FETCH/DATA: mem_ready and mem_* held constant until mem_valid sampled high or timeout; no preemption.
REQ-028 mem_valid high in FETCH/DATA: capture mem_rdata into the granted rdata output, deassert mem_ready at same edge, go DONE, pulse granted *_done with *_err=0.
REQ-029 Timeout counter cleared at grant, +1 per FETCH/DATA cycle without mem_valid; counter reaching TIMEOUT with no mem_valid: deassert mem_ready, rdata=0, *_err=1, go DONE.
REQ-030 mem_valid and timeout in the same cycle: mem_valid wins, err=0.
REQ-031 DONE: exactly one *_done high for one cycle; requests not sampled; next state IDLE.
REQ-032 Minimum transfer: grant edge, request cycle with mem_valid, DONE cycle = 3 cycles from req seen in IDLE to done; back-to-back grants every 3 cycles minimum.
REQ-033 mem_valid while mem_ready=0 is ignored; no state change.
REQ-034 Requester dropping req before done: transfer still completes, done still pulses.
REQ-035 *_rdata and *_err hold their values until that port's next done.

Reset
REQ-036 reset asserted (any cycle, including mid-transfer): state=IDLE, last_grant=fetch, counter=0; all outputs 0 (mem_ready, mem_instr, mem_addr, mem_wstrb, mem_wdata, done, rdata, err).
REQ-037 An aborted transfer is not resumed after reset; the requester reissues.

Verification
REQ-038 Fetch only: fetch_req, addr 0x104, mem_valid one cycle after mem_ready with rdata 0xDEADBEEF -> mem_instr=1, mem_addr=0x104, fetch_done pulse, fetch_rdata=0xDEADBEEF, fetch_err=0.
REQ-039 Tie from reset: both req, data_addr 0x2003, wstrb 4'b1000 -> data granted first (mem_addr=0x2000, mem_wstrb=4'b1000, mem_instr=0); fetch granted next; strict alternation while both are held.
REQ-040 Timeout: TIMEOUT=4, fetch_req, mem_valid never -> mem_ready drops after 4 cycles, fetch_done with fetch_err=1, fetch_rdata=0.
REQ-041 Reset mid-DATA: reset while mem_ready=1 -> all outputs 0 same cycle, IDLE after release, no data_done ever.
REQ-042 Spurious mem_valid in IDLE -> no done, no state change.
REQ-043 mem_valid coincident with timeout cycle -> err=0, rdata captured.
